// File: rtl/cam_frame_capture_ctrl.sv
// cam_frame_capture_ctrl
//   Captures whole camera frames from the 8->16-bit pixel packer into a linear
//   frame buffer. A software start arms the block; capture begins at the next
//   frame boundary (CamVsync falling) so a frame already in flight is never
//   partially written. One frame is captured, or frames are captured
//   back-to-back in continuous mode until abort. Lines and frames are counted,
//   and short or oversize frames are flagged.
//
// Parameters
//   H_WORDS  16-bit words kept per line (extra words in a line are dropped)
//   V_LINES  lines kept per frame (extra lines are dropped)
//   ADDR_W   write address width, H_WORDS*V_LINES <= 2**ADDR_W
//
// Ports
//   PCLK        pixel clock, rising edge
//   reset       asynchronous, active-high
//   start       1-cycle arm pulse, honoured only when idle
//   continuous  sampled with start: capture frames until abort
//   abort       1-cycle pulse, return to idle immediately
//   CamHsync    line valid (high during active line)
//   CamVsync    frame sync (high between frames)
//   pix_valid   packed word strobe
//   pix_data    packed pixel word
//   wr_addr     frame-buffer word address
//   wr_data     frame-buffer write data
//   wr_en       write strobe, one cycle per accepted word
//   busy        high while armed or capturing
//   frame_done  1-cycle pulse at the end of each captured frame
//   line_count  lines completed in the current/last frame, saturating
//   frame_count frames completed since start, wrapping
//   err_short   sticky: a frame ended with fewer than V_LINES lines
//   err_long    sticky: words or lines were dropped
module cam_frame_capture_ctrl #(
  parameter int H_WORDS = 640,
  parameter int V_LINES = 480,
  parameter int ADDR_W  = 19
) (
  input  logic              PCLK,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              CamHsync,
  input  logic              CamVsync,
  input  logic              pix_valid,
  input  logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              frame_done,
  output logic [9:0]        line_count,
  output logic [7:0]        frame_count,
  output logic              err_short,
  output logic              err_long
);

  localparam int WI = $clog2(H_WORDS + 1);
  localparam logic [WI-1:0]     H_LIM  = WI'(H_WORDS);
  localparam logic [9:0]        V_LIM  = 10'(V_LINES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE
  } state_t;

  state_t            state;
  logic              vs_d;
  logic              hs_d;
  logic              cont_r;
  logic [ADDR_W-1:0] line_base;
  logic [WI-1:0]     word_idx;

  logic       vs_fall;
  logic       vs_rise;
  logic       hs_fall;
  logic       in_cap;
  logic       line_ok;
  logic       word_try;
  logic       accept;
  logic       reject;
  logic [9:0] lc_sat;
  logic [9:0] lc_after_hs;

  always_comb begin
    vs_fall  = vs_d & ~CamVsync;
    vs_rise  = ~vs_d & CamVsync;
    hs_fall  = hs_d & ~CamHsync;
    in_cap   = (state == S_CAPTURE);
    line_ok  = (line_count < V_LIM);
    word_try = in_cap & pix_valid & CamHsync;
    accept   = word_try & (word_idx < H_LIM) & line_ok;
    reject   = word_try & ~((word_idx < H_LIM) & line_ok);
    lc_sat   = (line_count == 10'h3FF) ? line_count : line_count + 10'd1;
    // A line ending on the frame-closing cycle is counted before the
    // short-frame test.
    lc_after_hs = hs_fall ? lc_sat : line_count;
  end

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      vs_d        <= 1'b1;
      hs_d        <= 1'b0;
      cont_r      <= 1'b0;
      line_base   <= '0;
      word_idx    <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_en       <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      line_count  <= '0;
      frame_count <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      vs_d       <= CamVsync;
      hs_d       <= CamHsync;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state       <= S_ARM;
              busy        <= 1'b1;
              cont_r      <= continuous;
              line_count  <= '0;
              frame_count <= '0;
              err_short   <= 1'b0;
              err_long    <= 1'b0;
            end
          end

          S_ARM: begin
            if (vs_fall) begin
              state      <= S_CAPTURE;
              line_base  <= '0;
              word_idx   <= '0;
              line_count <= '0;
            end
          end

          S_CAPTURE: begin
            if (accept) begin
              wr_en    <= 1'b1;
              wr_data  <= pix_data;
              wr_addr  <= line_base + ADDR_W'(word_idx);
              word_idx <= word_idx + WI'(1);
            end
            if (reject) begin
              err_long <= 1'b1;
            end
            // Running line base avoids a line*H_WORDS multiply; short lines
            // still advance by a full line so addresses stay frame-aligned.
            if (hs_fall) begin
              word_idx   <= '0;
              line_count <= lc_sat;
              if (line_ok) begin
                line_base <= line_base + H_STEP;
              end else begin
                err_long <= 1'b1;
              end
            end
            if (vs_rise) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
              if (lc_after_hs < V_LIM) begin
                err_short <= 1'b1;
              end
              if (cont_r) begin
                state <= S_ARM;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_capture_ctrl.sv
// Directed bench for cam_frame_capture_ctrl using a reduced 8x6 frame.
module tb_cam_frame_capture_ctrl;

  localparam int HW = 8;
  localparam int VL = 6;
  localparam int AW = 7;

  logic          PCLK = 1'b0;
  logic          reset;
  logic          start;
  logic          continuous;
  logic          abort;
  logic          CamHsync;
  logic          CamVsync;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_en;
  logic          busy;
  logic          frame_done;
  logic [9:0]    line_count;
  logic [7:0]    frame_count;
  logic          err_short;
  logic          err_long;

  cam_frame_capture_ctrl #(
    .H_WORDS(HW),
    .V_LINES(VL),
    .ADDR_W (AW)
  ) dut (
    .PCLK       (PCLK),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .abort      (abort),
    .CamHsync   (CamHsync),
    .CamVsync   (CamVsync),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .busy       (busy),
    .frame_done (frame_done),
    .line_count (line_count),
    .frame_count(frame_count),
    .err_short  (err_short),
    .err_long   (err_long)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  // Write log filled by the monitor; the directed sequence consumes it from rd.
  int got_a[$];
  int got_d[$];
  int fd_cnt = 0;
  always @(negedge PCLK) begin
    if (wr_en === 1'b1) begin
      got_a.push_back(int'(wr_addr));
      got_d.push_back(int'(wr_data));
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  int exp_a[$];
  int exp_d[$];
  int rd = 0;
  int seq = 0;
  int m_line = 0;
  bit exp_cap = 1'b0;
  int fd0 = 0;

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    int mism;
    n = got_a.size() - rd;
    chk({tag, "_count"}, 32'(n), 32'(exp_a.size()));
    mism = 0;
    for (int i = 0; i < n && i < exp_a.size(); i++) begin
      if (got_a[rd + i] != exp_a[i] || got_d[rd + i] != exp_d[i]) mism++;
    end
    chk({tag, "_seq"}, 32'(mism), 32'd0);
    rd = got_a.size();
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic drive_word(input bit push);
    pix_valid = 1'b1;
    pix_data  = 16'(seq * 37 + 5);
    if (push) begin
      exp_a.push_back(m_line * HW + (exp_a.size() - m_line * HW) * 0);
    end
    seq++;
  endtask

  task automatic send_line(input int n, input bit close_vs);
    CamHsync = 1'b1;
    for (int w = 0; w < n; w++) begin
      pix_valid = 1'b1;
      pix_data  = 16'(seq * 37 + 5);
      seq++;
      if (exp_cap && m_line < VL && w < HW) begin
        exp_a.push_back(m_line * HW + w);
        exp_d.push_back(int'(pix_data));
      end
      tick;
    end
    pix_valid = 1'b0;
    CamHsync  = 1'b0;
    if (close_vs) CamVsync = 1'b1;
    m_line++;
    tick;
    tick;
  endtask

  task automatic frame_open;
    CamVsync = 1'b1;
    tick;
    tick;
    CamVsync = 1'b0;
    m_line = 0;
    tick;
    tick;
  endtask

  task automatic frame_close;
    CamVsync = 1'b1;
    tick;
    tick;
    tick;
  endtask

  task automatic pulse_start(input bit cont);
    continuous = cont;
    start = 1'b1;
    tick;
    start = 1'b0;
    continuous = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    CamHsync = 1'b0; CamVsync = 1'b1; pix_valid = 1'b0; pix_data = '0;
    repeat (3) tick;
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_wr_en",  32'(wr_en), 32'd0);
    chk("rst_fdone",  32'(frame_done), 32'd0);
    chk("rst_lines",  32'(line_count), 32'd0);
    chk("rst_frames", 32'(frame_count), 32'd0);
    chk("rst_eshort", 32'(err_short), 32'd0);
    chk("rst_elong",  32'(err_long), 32'd0);
    chk("rst_addr",   32'(wr_addr), 32'd0);
    chk("rst_data",   32'(wr_data), 32'd0);
    reset = 1'b0;
    tick;

    // Single full frame.
    pulse_start(1'b0);
    chk("t1_busy_arm", 32'(busy), 32'd1);
    exp_cap = 1'b1;
    fd0 = fd_cnt;
    frame_open;
    for (int l = 0; l < VL; l++) send_line(HW, 1'b0);
    frame_close;
    chk("t1_last_addr", 32'(got_a[got_a.size() - 1]), 32'(HW * VL - 1));
    compare_writes("t1");
    chk("t1_fdone",  32'(fd_cnt - fd0), 32'd1);
    chk("t1_frames", 32'(frame_count), 32'd1);
    chk("t1_lines",  32'(line_count), 32'(VL));
    chk("t1_eshort", 32'(err_short), 32'd0);
    chk("t1_elong",  32'(err_long), 32'd0);
    chk("t1_busy",   32'(busy), 32'd0);
    exp_cap = 1'b0;
    frame_open;
    send_line(HW, 1'b0);
    send_line(HW, 1'b0);
    frame_close;
    compare_writes("t1_idle");

    // Start while a frame is already in progress.
    CamVsync = 1'b0;
    tick;
    tick;
    pulse_start(1'b0);
    send_line(HW, 1'b0);
    send_line(HW, 1'b0);
    frame_close;
    chk("t2_busy_armed", 32'(busy), 32'd1);
    compare_writes("t2_pre");
    exp_cap = 1'b1;
    frame_open;
    for (int l = 0; l < VL; l++) send_line(HW, 1'b0);
    frame_close;
    chk("t2_first_addr", 32'(got_a[rd]), 32'd0);
    compare_writes("t2");
    chk("t2_frames", 32'(frame_count), 32'd1);

    // Long line, short line, closing line ends on the vs_rise cycle.
    pulse_start(1'b0);
    fd0 = fd_cnt;
    frame_open;
    send_line(HW + 2, 1'b0);
    send_line(HW - 1, 1'b0);
    chk("t3_line2_base", 32'(exp_a.size()), 32'(2 * HW - 1));
    send_line(HW, 1'b0);
    send_line(HW, 1'b0);
    send_line(HW, 1'b0);
    send_line(HW, 1'b1);
    frame_close;
    compare_writes("t3");
    chk("t3_elong",  32'(err_long), 32'd1);
    chk("t3_eshort", 32'(err_short), 32'd0);
    chk("t3_lines",  32'(line_count), 32'(VL));
    chk("t3_fdone",  32'(fd_cnt - fd0), 32'd1);

    // Short frame.
    pulse_start(1'b0);
    fd0 = fd_cnt;
    frame_open;
    for (int l = 0; l < VL - 1; l++) send_line(HW, 1'b0);
    frame_close;
    compare_writes("t4s");
    chk("t4s_lines",  32'(line_count), 32'(VL - 1));
    chk("t4s_eshort", 32'(err_short), 32'd1);
    chk("t4s_elong",  32'(err_long), 32'd0);
    chk("t4s_fdone",  32'(fd_cnt - fd0), 32'd1);

    // Oversize frame: extra lines must never be written.
    pulse_start(1'b0);
    frame_open;
    for (int l = 0; l < VL + 2; l++) send_line(HW, 1'b0);
    frame_close;
    compare_writes("t4l");
    chk("t4l_lines",  32'(line_count), 32'(VL + 2));
    chk("t4l_elong",  32'(err_long), 32'd1);
    chk("t4l_eshort", 32'(err_short), 32'd0);

    // Continuous mode, abort inside the third frame.
    pulse_start(1'b1);
    fd0 = fd_cnt;
    for (int f = 0; f < 2; f++) begin
      frame_open;
      for (int l = 0; l < VL; l++) send_line(HW, 1'b0);
      frame_close;
    end
    chk("t5_frames2", 32'(frame_count), 32'd2);
    chk("t5_busy2",   32'(busy), 32'd1);
    frame_open;
    send_line(HW, 1'b0);
    send_line(HW, 1'b0);
    CamHsync = 1'b1;
    for (int w = 0; w < 3; w++) begin
      pix_valid = 1'b1;
      pix_data  = 16'(seq * 37 + 5);
      seq++;
      exp_a.push_back(m_line * HW + w);
      exp_d.push_back(int'(pix_data));
      tick;
    end
    pix_data = 16'(seq * 37 + 5);
    seq++;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t5_wr_en_off", 32'(wr_en), 32'd0);
    chk("t5_busy_off",  32'(busy), 32'd0);
    for (int w = 0; w < 3; w++) begin
      pix_data = 16'(seq * 37 + 5);
      seq++;
      tick;
    end
    pix_valid = 1'b0;
    CamHsync  = 1'b0;
    tick;
    tick;
    frame_close;
    compare_writes("t5");
    chk("t5_fdone",  32'(fd_cnt - fd0), 32'd2);
    chk("t5_frames", 32'(frame_count), 32'd2);
    chk("t5_lines",  32'(line_count), 32'd2);
    chk("t5_busy",   32'(busy), 32'd0);

    // Asynchronous reset mid-line.
    exp_cap = 1'b0;
    pulse_start(1'b0);
    frame_open;
    send_line(HW, 1'b0);
    CamHsync  = 1'b1;
    pix_valid = 1'b1;
    tick;
    tick;
    chk("t6_wr_en_on", 32'(wr_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_wr_en", 32'(wr_en), 32'd0);
    chk("t6_busy",  32'(busy), 32'd0);
    chk("t6_lines", 32'(line_count), 32'd0);
    chk("t6_addr",  32'(wr_addr), 32'd0);
    pix_valid = 1'b0;
    CamHsync  = 1'b0;
    CamVsync  = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    rd = got_a.size();
    exp_a.delete();
    exp_d.delete();
    frame_open;
    for (int l = 0; l < VL; l++) send_line(HW, 1'b0);
    frame_close;
    compare_writes("t6_nostart");
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
